// File: rtl/insn_prefetch_pkg.sv
// insn_prefetch_pkg: shared fetch constants and the queued fetch-entry type
package insn_prefetch_pkg;
    localparam logic [31:0] RESET_PC_DEF = 32'h0;
    localparam logic [31:0] WORD_BYTES   = 32'd4;
    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/insn_fifo.sv
// insn_fifo: fetch-entry queue with synchronous flush and a registered head
// Ports: clk/rst (async active-high), flush_i clears, push_i/push_data_i write,
// pop_i consumes the head, head_o is the head register (holds last value when empty),
// count_o is the occupancy.
module insn_fifo
    import insn_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  fetch_entry_t                 push_data_i,
    input  logic                         pop_i,
    output fetch_entry_t                 head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    fetch_entry_t mem_q [DEPTH];
    fetch_entry_t head_q, head_d;
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] count_q, count_d, rem;
    logic pop_eff;
    always_comb begin
        pop_eff = pop_i && count_q != '0;
        rem     = count_q - CW'(pop_eff);
        rd_d    = flush_i ? '0 : rd_q + PW'(pop_eff);
        wr_d    = flush_i ? '0 : wr_q + PW'(push_i);
        count_d = flush_i ? '0 : rem + CW'(push_i);
        // the head is the oldest surviving entry, or the pushed one if nothing else remains
        head_d  = count_d == '0 ? head_q : rem == '0 ? push_data_i : mem_q[rd_d];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            head_q  <= head_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_q] <= push_data_i;
    end
    assign head_o  = head_q;
    assign count_o = count_q;
endmodule

// File: rtl/insn_prefetch.sv
// insn_prefetch: sequential instruction prefetch with credit-limited issue and redirect flush
// Ports: xclk/xreset (async active-high); imem_req_* fetch request channel;
// imem_rsp_* in-order responses; redirect_* flush and restart; insn_* queue head to decode.
module insn_prefetch
    import insn_prefetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        xclk,
    input  logic        xreset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        insn_valid,
    output logic [31:0] insn,
    output logic [31:0] insn_pc,
    input  logic        insn_ready
);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW:0] CAP = (CW+1)'(DEPTH);
    logic [31:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] out_q, out_d, drop_q, drop_d, fifo_count;
    logic fire, rsp_ok, push, pop;
    fetch_entry_t head;
    always_comb begin
        // queued plus in-flight fetches never exceed DEPTH, so the queue cannot overflow
        imem_req_valid = !xreset && !redirect_valid && ({1'b0, fifo_count} + {1'b0, out_q} < CAP);
        fire       = imem_req_valid && imem_req_ready;
        rsp_ok     = imem_rsp_valid && out_q != '0;
        push       = rsp_ok && drop_q == '0 && !redirect_valid;
        pop        = insn_valid && insn_ready;
        out_d      = out_q + CW'(fire) - CW'(rsp_ok);
        // on redirect every fetch still in flight becomes stale
        drop_d     = redirect_valid ? out_q - CW'(rsp_ok) : drop_q - CW'(rsp_ok && drop_q != '0);
        fetch_pc_d = redirect_valid ? {redirect_pc[31:2], 2'b00} : fetch_pc_q + (fire ? WORD_BYTES : 32'd0);
        rsp_pc_d   = redirect_valid ? {redirect_pc[31:2], 2'b00} : rsp_pc_q + (push ? WORD_BYTES : 32'd0);
    end
    always_ff @(posedge xclk or posedge xreset) begin
        if (xreset) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
        end
    end
    insn_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (xclk),
        .rst         (xreset),
        .flush_i     (redirect_valid),
        .push_i      (push),
        .push_data_i ('{insn: imem_rsp_data, pc: rsp_pc_q}),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (fifo_count)
    );
    assign imem_req_addr = fetch_pc_q;
    assign insn_valid    = fifo_count != '0;
    assign insn          = head.insn;
    assign insn_pc       = head.pc;
endmodule

// File: tb/tb_insn_prefetch.sv
// tb_insn_prefetch: randomized bench against a request-level reference model
module tb_insn_prefetch;
    import insn_prefetch_pkg::*;
    localparam int DEPTH = 4;
    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;
    logic        xclk = 1'b0;
    logic        xreset = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        insn_valid;
    logic [31:0] insn;
    logic [31:0] insn_pc;
    logic        insn_ready = 1'b0;
    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int rsp_pct = 100;
    req_t pend[$];
    fetch_entry_t mq[$];
    fetch_entry_t last = '0;
    logic [31:0] m_fetch = '0;
    insn_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .xclk           (xclk),
        .xreset         (xreset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .insn_valid     (insn_valid),
        .insn           (insn),
        .insn_pc        (insn_pc),
        .insn_ready     (insn_ready)
    );
    initial forever #5 xclk = ~xclk;
    always @(posedge xclk) begin
        if (!xreset) begin
            assert (!(imem_rsp_valid && dut.out_q == '0)) else $error("FAIL proto: response with nothing outstanding");
            assert (dut.fifo_count <= DEPTH) else $error("FAIL fifo_count over DEPTH: %0d", dut.fifo_count);
        end
    end
    function automatic logic [31:0] dat(input logic [31:0] a);
        return ~a ^ 32'h1357_9BDF;
    endfunction
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask
    task automatic step(input bit rdy, input bit irdy, input bit redir, input logic [31:0] rpc, input int lat);
        bit r, e_req, do_pop;
        req_t p;
        @(negedge xclk);
        r = pend.size() != 0 && pend[0].due <= cyc && $urandom_range(99, 0) < rsp_pct;
        imem_rsp_valid = r;
        imem_rsp_data  = r ? dat(pend[0].addr) : $urandom;
        imem_req_ready = rdy;
        insn_ready     = irdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        #1;
        e_req = !redir && (mq.size() + pend.size() < DEPTH);
        if (mq.size() != 0) last = mq[0];
        chk("req_valid", imem_req_valid, e_req);
        chk("req_addr", imem_req_addr, m_fetch);
        chk("insn_valid", insn_valid, mq.size() != 0);
        chk("insn", insn, last.insn);
        chk("insn_pc", insn_pc, last.pc);
        do_pop = irdy && mq.size() != 0 && !redir;
        if (do_pop) void'(mq.pop_front());
        if (r) begin
            p = pend.pop_front();
            if (!p.stale && !redir) mq.push_back('{insn: dat(p.addr), pc: p.addr});
        end
        if (redir) begin
            mq.delete();
            foreach (pend[i]) pend[i].stale = 1'b1;
            m_fetch = {rpc[31:2], 2'b00};
        end
        if (e_req && rdy) begin
            pend.push_back('{addr: m_fetch, due: cyc + lat, stale: 1'b0});
            m_fetch += 32'd4;
        end
        cyc++;
    endtask
    task automatic do_reset(input int delay);
        @(negedge xclk);
        #(delay);
        xreset = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        insn_ready = 1'b0;
        #1;
        chk("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_insn_valid", insn_valid, 1'b0);
        chk("rst_insn", insn, 32'h0);
        chk("rst_insn_pc", insn_pc, 32'h0);
        pend.delete();
        mq.delete();
        last = '0;
        m_fetch = '0;
        @(negedge xclk);
        xreset = 1'b0;
    endtask
    initial begin
        do_reset(0);
        for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 1);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 1);
        chk("full_count", dut.fifo_count, DEPTH);
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 3);
        step(1, 1, 1, 32'h103, 3);
        for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 3);
        step(1, 1, 1, 32'hFFFF_FFF5, 1);
        for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 1);
        for (int i = 0; i < 6; i++) step(1, i < 3, 0, 0, 1);
        step(1, 1, 1, 32'h40, 2);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 1);
        rsp_pct = 70;
        for (int i = 0; i < 800; i++) begin
            logic [31:0] rpc;
            rpc = $urandom_range(3, 0) == 0 ? 32'hFFFF_FFF0 | 32'($urandom_range(15, 0)) : $urandom;
            step($urandom_range(3, 0) != 0, $urandom_range(2, 0) != 0, $urandom_range(19, 0) == 0, rpc, $urandom_range(4, 1));
        end
        rsp_pct = 100;
        for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 1);
        chk("full_before_reset", dut.fifo_count, DEPTH);
        do_reset(2);
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/insn_prefetch.md
Name: insn_prefetch

Overview:
Instruction fetch/prefetch stage directly upstream of decode. It issues sequential word fetches to instruction memory over a valid/ready request channel and collects in-order responses into a small queue. It presents each instruction with its PC to decode, whose immediate generator consumes `insn`. A redirect (branch or jump) flushes the queue and discards in-flight responses.

Parameters:
DEPTH, 4, queue entries; also the cap on (queued + in-flight) fetches; power of 2, at least 2.
RESET_PC, 32'h0, first fetch address after reset.

Ports:
xclk  in  1  clock, rising edge.
xreset  in  1  asynchronous, active-high reset.
imem_req_valid  out  1  fetch request valid.
imem_req_addr  out  32  fetch word address; bits [1:0] are always 0.
imem_req_ready  in  1  memory accepts the request this cycle.
imem_rsp_valid  in  1  response data valid; responses are in order, latency of 1 or more cycles.
imem_rsp_data  in  32  fetched instruction.
redirect_valid  in  1  flush and restart fetch this cycle.
redirect_pc  in  32  new fetch PC; bits [1:0] are ignored and forced to 0.
insn_valid  out  1  queue head valid.
insn  out  32  queue head instruction.
insn_pc  out  32  PC of the queue head.
insn_ready  in  1  decode consumes the head this cycle.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - fetch_pc = rsp_pc = RESET_PC.
  - Queue empty; outstanding = drop = 0.
  - All outputs are 0: imem_req_valid, insn_valid, insn, insn_pc = 0; imem_req_addr = RESET_PC.
- State:
  - fetch_pc: next request address.
  - rsp_pc: PC to tag the next kept response with.
  - outstanding: accepted requests not yet responded; width clog2(DEPTH+1).
  - drop: responses still to be discarded; same width.
  - count: queue occupancy.
- Request:
  - imem_req_valid = !redirect_valid && (count + outstanding < DEPTH); compare at width clog2(DEPTH+1)+1.
  - imem_req_addr = fetch_pc.
  - On valid && ready: fetch_pc += 4 (wraps modulo 2^32); outstanding += 1.
- Response (imem_rsp_valid):
  - outstanding -= 1.
  - If drop != 0: drop -= 1 and the data is discarded.
  - Otherwise push {imem_rsp_data, rsp_pc} and rsp_pc += 4.
  - A response while outstanding == 0 is a protocol error: ignore it and flag it with a bench assertion.
- Output:
  - insn_valid = (count != 0); insn and insn_pc come from the head register.
  - Pop on insn_valid && insn_ready.
  - Latency: a response in cycle N is visible at insn_valid in cycle N+1.
  - When empty, insn and insn_pc hold their last values. They are 0 after reset.
- Simultaneous push and pop: allowed at any occupancy, including full; count is unchanged.
- Overflow cannot occur because of the issue credit. Keep an assertion that count never exceeds DEPTH.
- Redirect cycle (highest priority):
  - Queue cleared; any pop this cycle is ignored for count purposes.
  - fetch_pc = rsp_pc = {redirect_pc[31:2], 2'b00}.
  - No request issued (req_valid is 0).
  - A response arriving this cycle is discarded.
  - drop = outstanding - rsp_valid; outstanding = outstanding - rsp_valid.
  - insn_valid = 0 from the next cycle.
- Back-to-back redirects: each one restarts from its own PC. drop accumulates correctly because it always equals the current in-flight count.
- Reset mid-operation: all state is cleared immediately. The memory system must also be reset by the same xreset, so no stale responses arrive afterwards.

Decomposition:
- Shared package (riscv fetch pkg): RESET_PC default, word size 4, and a fetch-entry struct {insn[31:0], pc[31:0]}.
- One sub-module: insn_fifo.
  - Parameterised DEPTH, 64-bit entries.
  - Synchronous flush, push/pop, count output.
  - Head register output.
- The top level holds the PC counters, credit logic and drop counter.

Test Plan:
- Reset, then memory always ready with 1-cycle latency and insn_ready = 1 → requests at addresses 0x0, 0x4, 0x8, … on consecutive cycles; insn_pc sequence 0x0, 0x4, 0x8 with the matching data; sustained throughput of 1 per cycle.
- insn_ready = 0, DEPTH = 4 → exactly 4 requests issued, then imem_req_valid = 0; count = 4. Release insn_ready → 4 pops in order, then fetch resumes at 0x10.
- 3 requests in flight (latency 3), then redirect to 0x103 → next request at 0x100; the 3 old responses are discarded; the first insn_pc = 0x100.
- Redirect in the same cycle as a response and a pop, with queue count = 2 → queue empty next cycle; drop equals outstanding − 1; no stale instruction appears.
- fetch_pc = 0xFFFFFFFC → next request at 0x00000000, and insn_pc wraps the same way.
- xreset asserted mid-stream with the queue full → outputs go to 0 asynchronously; after release the first request is at RESET_PC.
